divu_seq_unit: RTL and testbench

//  Sequential unsigned divider that consumes the 6-bit ALU function code from the
//  ALU control block. When the code is DIVU it runs a 32-iteration restoring

---
 rtl/divu_seq_unit.sv | 117 +++++++++++
 tb/tb_divu_seq_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/divu_seq_unit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, triggered by
// the DIVU function code; writes remainder/quotient to HiLo when finished.
module divu_seq_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [5:0]  DIVU_CODE = 6'd27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       signal_in,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              is_code;
  logic [WIDTH:0]    trial;
  logic              fits;
  logic [WIDTH-1:0]  rem_next;
  logic [WIDTH-1:0]  quo_next;

  always_comb begin
    is_code  = (signal_in == DIVU_CODE);
    // Shifted remainder kept one bit wider so the compare never overflows;
    // the subtraction result is always < divisor, so WIDTH bits suffice.
    trial    = {rem_q, quo_q[WIDTH-1]};
    fits     = (trial >= {1'b0, dvsr_q});
    rem_next = fits ? (trial[WIDTH-1:0] - dvsr_q) : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], fits};

    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (!is_code) armed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (is_code && armed_q) begin
          quo_d   = dividend;
          dvsr_d  = divisor;
          rem_d   = '0;
          cnt_d   = '0;
          armed_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!is_code) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            hi_d    = rem_next;
            lo_d    = quo_next;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign hilo_we = (state_q == S_DONE);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_divu_seq_unit.sv
// Directed self-checking bench for divu_seq_unit: latency, results, aborts,
// retrigger behaviour and asynchronous reset.
module tb_divu_seq_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [5:0]   signal_in;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         hilo_we;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int we_base;

  divu_seq_unit #(.WIDTH(W), .DIVU_CODE(6'd27)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .signal_in (signal_in),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .hilo_we   (hilo_we),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (hilo_we) we_cnt++;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch a division at the next edge and hold the code until done.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_q, input logic [W-1:0] exp_r);
    int edges;
    int base;
    @(negedge clk);
    base      = we_cnt;
    dividend  = a;
    divisor   = b;
    signal_in = 6'd27;
    edges     = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 2) begin
        dividend = ~a;
        divisor  = ~b;
      end
    end while (!done && edges < 40);
    check_eq({tag, "_latency"}, edges, 33);
    check_eq({tag, "_lo"}, lo, exp_q);
    check_eq({tag, "_hi"}, hi, exp_r);
    check_eq({tag, "_we"}, {31'b0, hilo_we}, 1);
    check_eq({tag, "_busy"}, {31'b0, busy}, 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_clr"}, {31'b0, done}, 0);
    check_eq({tag, "_pulses"}, we_cnt - base, 1);
  endtask

  task automatic drop_code();
    @(negedge clk);
    signal_in = 6'd0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    signal_in = 6'd0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_done", {31'b0, done}, 0);
    check_eq("rst_we", {31'b0, hilo_we}, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: one-cycle request aborts, then full run
    @(negedge clk);
    dividend  = 32'd100;
    divisor   = 32'd7;
    signal_in = 6'd27;
    @(negedge clk);
    check_eq("t1_busy_run", {31'b0, busy}, 1);
    signal_in = 6'd0;
    we_base   = we_cnt;
    @(negedge clk);
    check_eq("t1_abort_busy", {31'b0, busy}, 0);
    repeat (40) @(negedge clk);
    check_eq("t1_abort_nowe", we_cnt - we_base, 0);
    check_eq("t1_abort_lo", lo, 0);
    run_div("t1", 32'd100, 32'd7, 32'd14, 32'd2);
    drop_code();

    // T2: boundary operands
    run_div("t2a", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    drop_code();
    run_div("t2b", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    drop_code();

    // T3: divide by zero
    run_div("t3", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    drop_code();

    // T4: held code triggers once, rearm triggers again
    we_base = we_cnt;
    run_div("t4a", 32'd77, 32'd5, 32'd15, 32'd2);
    repeat (66) @(negedge clk);
    check_eq("t4_hold_pulses", we_cnt - we_base, 1);
    check_eq("t4_hold_busy", {31'b0, busy}, 0);
    drop_code();
    run_div("t4b", 32'd123456789, 32'd1000, 32'd123456, 32'd789);
    drop_code();

    // T5: code changes at iteration 10
    @(negedge clk);
    dividend  = 32'd50000;
    divisor   = 32'd7;
    signal_in = 6'd27;
    repeat (11) @(negedge clk);
    check_eq("t5_busy_mid", {31'b0, busy}, 1);
    signal_in = 6'd32;
    we_base   = we_cnt;
    @(negedge clk);
    check_eq("t5_busy_fall", {31'b0, busy}, 0);
    repeat (40) @(negedge clk);
    check_eq("t5_nowe", we_cnt - we_base, 0);
    check_eq("t5_lo_kept", lo, 32'd123456);
    check_eq("t5_hi_kept", hi, 32'd789);
    drop_code();

    // T6: asynchronous reset at iteration 20
    @(negedge clk);
    dividend  = 32'd999;
    divisor   = 32'd3;
    signal_in = 6'd27;
    repeat (21) @(negedge clk);
    check_eq("t6_busy_pre", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_busy", {31'b0, busy}, 0);
    check_eq("t6_done", {31'b0, done}, 0);
    check_eq("t6_we", {31'b0, hilo_we}, 0);
    check_eq("t6_hi", hi, 0);
    check_eq("t6_lo", lo, 0);
    @(negedge clk);
    signal_in = 6'd0;
    rst_n     = 1'b1;
    @(negedge clk);
    run_div("t6", 32'd1000, 32'd10, 32'd100, 32'd0);
    drop_code();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
